dm_responder: RTL and testbench

//   Data-memory responder for the core's load/store port: the target end of a valid/ready request/response link.

---
 rtl/dm_responder.sv | 219 +++++++++++++++++++++
 tb/tb_dm_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// Data-memory responder: valid/ready target for the core's load/store port with
// programmable wait states, byte/half/word access and MIPS-style load extension.
module dm_responder #(
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [5:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       o_resp_rdata,
  output logic              o_resp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [3:0]          r_cnt;
  logic [5:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;
  logic                r_err;
  logic [31:0]         r_mem [DEPTH];

  logic                w_accept;
  logic                w_req_err;
  logic [ADDR_W-3:0]   w_index;
  logic [31:0]         w_word;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load_data;
  logic [31:0]         w_store_data;
  logic [3:0]          w_store_be;
  logic                w_is_store;
  logic                w_mem_we;

  function automatic logic reqError(input logic [5:0] op, input logic [1:0] lsb);
    case (op)
      OP_LB, OP_LBU, OP_SB: reqError = 1'b0;
      OP_LH, OP_LHU, OP_SH: reqError = lsb[0];
      OP_LW, OP_SW:         reqError = |lsb;
      default:              reqError = 1'b1;
    endcase
  endfunction

  assign o_req_ready  = i_rst_n & (r_state == S_IDLE);
  assign w_accept     = i_req_valid & o_req_ready;
  assign w_req_err    = reqError(i_req_op, i_req_addr[1:0]);
  assign o_resp_valid = (r_state == S_RESP);
  assign o_resp_rdata = r_rdata;
  assign o_resp_err   = r_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err) begin
            w_next_state = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            w_next_state = S_ACCESS;
          end else begin
            w_next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: w_next_state = S_RESP;
      S_RESP: begin
        if (i_resp_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= WAIT_INIT;
    end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Request fields are latched at accept so the core may change its inputs freely afterwards.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op    <= 6'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= i_req_op;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
        r_rdata <= 32'd0;
        r_err   <= w_req_err;
      end else if (r_state == S_ACCESS) begin
        r_rdata <= w_is_store ? 32'd0 : w_load_data;
      end else if (r_state == S_RESP && i_resp_ready) begin
        r_rdata <= 32'd0;
        r_err   <= 1'b0;
      end
    end
  end

  assign w_index = r_addr[ADDR_W-1:2];
  assign w_word  = r_mem[w_index];

  always_comb begin
    w_byte = w_word[7:0];
    case (r_addr[1:0])
      2'd0: w_byte = w_word[7:0];
      2'd1: w_byte = w_word[15:8];
      2'd2: w_byte = w_word[23:16];
      2'd3: w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase
  end

  assign w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_load_data = 32'd0;
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'd0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'd0, w_half};
      OP_LW:   w_load_data = w_word;
      default: w_load_data = 32'd0;
    endcase
  end

  // Store data is replicated across all lanes; the byte enables pick the addressed ones.
  always_comb begin
    w_is_store   = 1'b0;
    w_store_be   = 4'b0000;
    w_store_data = r_wdata;
    case (r_op)
      OP_SB: begin
        w_is_store   = 1'b1;
        w_store_be   = 4'b0001 << r_addr[1:0];
        w_store_data = {4{r_wdata[7:0]}};
      end
      OP_SH: begin
        w_is_store   = 1'b1;
        w_store_be   = r_addr[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{r_wdata[15:0]}};
      end
      OP_SW: begin
        w_is_store   = 1'b1;
        w_store_be   = 4'b1111;
        w_store_data = r_wdata;
      end
      default: begin
        w_is_store   = 1'b0;
        w_store_be   = 4'b0000;
        w_store_data = r_wdata;
      end
    endcase
  end

  assign w_mem_we = (r_state == S_ACCESS) & w_is_store;

  // The array is deliberately not reset; an async reset forces IDLE so an aborted store never lands.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_store_be[i]) begin
          r_mem[w_index][8*i +: 8] <= w_store_data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: two instances (2 and 0 wait states) checked
// against a byte-array reference model with latency, stall and reset-abort checks.
module tb_dm_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;

  typedef struct {
    logic [5:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          acceptEdge;
  } req_t;

  logic        clk;
  logic        rstN      [2];
  logic        reqValid  [2];
  logic        reqReady  [2];
  logic [5:0]  reqOp     [2];
  logic [11:0] reqAddr   [2];
  logic [31:0] reqWdata  [2];
  logic        respValid [2];
  logic        respReady [2];
  logic [31:0] respRdata [2];
  logic        respErr   [2];

  int          total;
  int          bad;
  int          cyc;
  bit          seen      [2];
  bit          randReady;
  req_t        expQ      [2][$];
  byte unsigned refMem[int];

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(W0)) dut2 (
    .i_clk(clk), .i_rst_n(rstN[0]), .i_req_valid(reqValid[0]), .o_req_ready(reqReady[0]),
    .i_req_op(reqOp[0]), .i_req_addr(reqAddr[0]), .i_req_wdata(reqWdata[0]),
    .o_resp_valid(respValid[0]), .i_resp_ready(respReady[0]),
    .o_resp_rdata(respRdata[0]), .o_resp_err(respErr[0])
  );

  dm_responder #(.ADDR_W(12), .WAIT_CYCLES(W1)) dut0 (
    .i_clk(clk), .i_rst_n(rstN[1]), .i_req_valid(reqValid[1]), .o_req_ready(reqReady[1]),
    .i_req_op(reqOp[1]), .i_req_addr(reqAddr[1]), .i_req_wdata(reqWdata[1]),
    .o_resp_valid(respValid[1]), .i_resp_ready(respReady[1]),
    .o_resp_rdata(respRdata[1]), .o_resp_err(respErr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Random backpressure on the slow instance, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (randReady) respReady[0] = ($urandom_range(0, 3) != 0);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Access size, signedness and direction of an opcode; size 0 means unsupported.
  function automatic void opInfo(input logic [5:0] op, output int size, output bit sgn, output bit isLoad);
    size = 0; sgn = 0; isLoad = 0;
    case (op)
      6'h20: begin size = 1; sgn = 1; isLoad = 1; end
      6'h21: begin size = 2; sgn = 1; isLoad = 1; end
      6'h23: begin size = 4; isLoad = 1; end
      6'h24: begin size = 1; isLoad = 1; end
      6'h25: begin size = 2; isLoad = 1; end
      6'h28: size = 1;
      6'h29: size = 2;
      6'h2B: size = 4;
      default: size = 0;
    endcase
  endfunction

  function automatic void refLoad(input int k, input logic [5:0] op, input logic [11:0] a,
                                  output logic [31:0] rd, output bit er, output bit kn);
    int size; bit sgn; bit isLoad; longint v; int idx;
    opInfo(op, size, sgn, isLoad);
    rd = 32'd0; kn = 1;
    er = (size == 0) ? 1'b1 : ((int'(a) % size) != 0);
    if (!er && isLoad) begin
      v = 0;
      for (int i = 0; i < size; i++) begin
        idx = k * 4096 + int'(a) + i;
        if (refMem.exists(idx)) v += longint'(refMem[idx]) << (8 * i);
        else kn = 0;
      end
      if (sgn && v >= (longint'(1) << (8 * size - 1))) v -= (longint'(1) << (8 * size));
      rd = v[31:0];
    end
  endfunction

  function automatic void refStore(input int k, input req_t e);
    int size; bit sgn; bit isLoad;
    opInfo(e.op, size, sgn, isLoad);
    if (size != 0 && !isLoad && (int'(e.addr) % size) == 0) begin
      for (int i = 0; i < size; i++) begin
        refMem[k * 4096 + int'(e.addr) + i] = byte'(e.wdata >> (8 * i));
      end
    end
  endfunction

  // Monitor: compares every cycle a response is presented, pops on handshake.
  task automatic monitorStep(input int k);
    req_t e; logic [31:0] er; bit ee; bit kn; int lat;
    if (rstN[k] === 1'b1 && respValid[k] === 1'b1) begin
      if (expQ[k].size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_resp inst%0d: got resp_valid=1 want no response", k);
      end else begin
        e = expQ[k][0];
        refLoad(k, e.op, e.addr, er, ee, kn);
        if (!seen[k]) begin
          seen[k] = 1;
          lat = ee ? 1 : ((k == 0) ? W0 + 2 : W1 + 2);
          checkOutput($sformatf("latency_inst%0d", k), 32'(cyc - e.acceptEdge + 1), 32'(lat));
        end
        if (kn) checkOutput($sformatf("rdata_inst%0d", k), respRdata[k], er);
        checkOutput($sformatf("err_inst%0d", k), 32'(respErr[k]), 32'(ee));
        checkOutput($sformatf("req_ready_in_resp_inst%0d", k), 32'(reqReady[k]), 32'd0);
        if (respReady[k] === 1'b1) begin
          refStore(k, e);
          void'(expQ[k].pop_front());
          seen[k] = 0;
        end
      end
    end
  endtask

  always @(negedge clk) monitorStep(0);
  always @(negedge clk) monitorStep(1);

  task automatic applyStimulus(input int k, input logic [5:0] op, input logic [11:0] a, input logic [31:0] wd);
    req_t e; bit ok;
    @(posedge clk); #1;
    reqValid[k] = 1'b1; reqOp[k] = op; reqAddr[k] = a; reqWdata[k] = wd;
    ok = 0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (reqReady[k] === 1'b1) begin
        ok = 1;
        e.op = op; e.addr = a; e.wdata = wd; e.acceptEdge = cyc + 1;
        expQ[k].push_back(e);
      end
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout inst%0d: got req_ready=0 want 1", k);
    end
    @(posedge clk); #1;
    reqValid[k] = 1'b0; reqOp[k] = $urandom; reqAddr[k] = $urandom; reqWdata[k] = $urandom;
  endtask

  task automatic waitIdle(input int k);
    bit ok = 0;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (expQ[k].size() == 0 && reqReady[k] === 1'b1) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL idle_timeout inst%0d: got pending=%0d want 0", k, expQ[k].size());
    end
  endtask

  task automatic waitResp(input int k);
    bit ok = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (respValid[k] === 1'b1) ok = 1;
    end
    if (!ok) begin
      total++; bad++;
      $display("[TB] FAIL resp_timeout inst%0d: got resp_valid=0 want 1", k);
    end
  endtask

  task automatic pulseReset(input int k, input string tag);
    rstN[k] = 1'b0;
    expQ[k].delete();
    seen[k] = 0;
    #1;
    checkOutput({tag, "_resp_valid"}, 32'(respValid[k]), 32'd0);
    checkOutput({tag, "_req_ready"},  32'(reqReady[k]),  32'd0);
    checkOutput({tag, "_rdata"},      respRdata[k],      32'd0);
    checkOutput({tag, "_err"},        32'(respErr[k]),   32'd0);
    repeat (2) @(posedge clk);
    #1 rstN[k] = 1'b1;
  endtask

  logic [5:0] opList [9];

  initial begin
    total = 0; bad = 0; randReady = 0;
    opList = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h2F};
    for (int k = 0; k < 2; k++) begin
      rstN[k] = 1'b0; reqValid[k] = 1'b0; reqOp[k] = 6'd0; reqAddr[k] = 12'd0;
      reqWdata[k] = 32'd0; respReady[k] = 1'b1; seen[k] = 0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready",  32'(reqReady[0]),  32'd0);
    checkOutput("reset_resp_valid", 32'(respValid[0]), 32'd0);
    checkOutput("reset_rdata",      respRdata[0],      32'd0);
    checkOutput("reset_err",        32'(respErr[0]),   32'd0);
    @(posedge clk); #1;
    rstN[0] = 1'b1; rstN[1] = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_req_ready", 32'(reqReady[0]), 32'd1);

    $display("[TB] directed word/byte/half accesses");
    applyStimulus(0, 6'h2B, 12'h010, 32'h11223344);
    applyStimulus(0, 6'h23, 12'h010, 32'h0);
    applyStimulus(0, 6'h28, 12'h011, 32'hFFFFFFAA);
    applyStimulus(0, 6'h23, 12'h010, 32'h0);
    applyStimulus(0, 6'h20, 12'h011, 32'h0);
    applyStimulus(0, 6'h24, 12'h011, 32'h0);
    applyStimulus(0, 6'h29, 12'h012, 32'h12348001);
    applyStimulus(0, 6'h21, 12'h012, 32'h0);
    applyStimulus(0, 6'h25, 12'h012, 32'h0);
    applyStimulus(0, 6'h23, 12'h010, 32'h0);
    waitIdle(0);
    checkOutput("model_word_0x010", {refMem[16'h13], refMem[16'h12], refMem[16'h11], refMem[16'h10]}, 32'h8001AA44);

    $display("[TB] error responses");
    applyStimulus(0, 6'h23, 12'h012, 32'h0);
    applyStimulus(0, 6'h29, 12'h013, 32'hFFFF);
    applyStimulus(0, 6'h2F, 12'h010, 32'hFFFFFFFF);
    applyStimulus(0, 6'h23, 12'h010, 32'h0);
    waitIdle(0);

    $display("[TB] response stall");
    @(posedge clk); #1 respReady[0] = 1'b0;
    applyStimulus(0, 6'h23, 12'h010, 32'h0);
    waitResp(0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 respReady[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("stall_release_req_ready",  32'(reqReady[0]),  32'd1);
    checkOutput("stall_release_resp_valid", 32'(respValid[0]), 32'd0);

    $display("[TB] reset abort during wait and during response");
    applyStimulus(0, 6'h2B, 12'h020, 32'hDEADBEEF);
    waitIdle(0);
    applyStimulus(0, 6'h2B, 12'h020, 32'h0BADF00D);
    #1 pulseReset(0, "abort_wait");
    applyStimulus(0, 6'h23, 12'h020, 32'h0);
    waitIdle(0);
    @(posedge clk); #1 respReady[0] = 1'b0;
    applyStimulus(0, 6'h23, 12'h010, 32'h0);
    waitResp(0);
    @(posedge clk); #1 pulseReset(0, "abort_resp");
    respReady[0] = 1'b1;
    applyStimulus(0, 6'h23, 12'h020, 32'h0);
    waitIdle(0);

    $display("[TB] randomized traffic with backpressure");
    for (int i = 0; i < 16; i++) applyStimulus(0, 6'h2B, 12'(12'h100 + 4 * i), $urandom);
    randReady = 1;
    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, opList[$urandom_range(0, 8)], 12'(12'h100 + $urandom_range(0, 63)), $urandom);
    end
    waitIdle(0);
    randReady = 0;
    @(posedge clk); #1 respReady[0] = 1'b1;

    $display("[TB] zero wait-state instance");
    applyStimulus(1, 6'h2B, 12'h020, 32'h55667788);
    applyStimulus(1, 6'h23, 12'h020, 32'h0);
    applyStimulus(1, 6'h28, 12'h023, 32'h000000C3);
    applyStimulus(1, 6'h20, 12'h023, 32'h0);
    applyStimulus(1, 6'h25, 12'h022, 32'h0);
    waitIdle(1);
    applyStimulus(1, 6'h2B, 12'h020, 32'h99999999);
    #1 pulseReset(1, "abort_access");
    applyStimulus(1, 6'h23, 12'h020, 32'h0);
    applyStimulus(1, 6'h21, 12'h021, 32'h0);
    waitIdle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
